// File: rtl/display_scan_ctrl_pkg.sv
// Shared calculator definitions: key-code constants used by the scan controller,
// the segment converter and the keypad decoder.
package display_scan_ctrl_pkg;

   typedef logic [3:0] key_t;

   localparam key_t KEY_PLUS = 4'hA;
   localparam key_t KEY_MIN  = 4'hB;
   localparam key_t KEY_MULT = 4'hC;
   localparam key_t KEY_DIV  = 4'hD;
   localparam key_t KEY_EQ   = 4'hE;
   localparam key_t KEY_NUL  = 4'hF;

endpackage

// File: rtl/refresh_tick_gen.sv
// Digit-slot prescaler: free-running count 0..REFRESH_DIV-1 with a terminal-count tick.
module refresh_tick_gen #(
   parameter int REFRESH_DIV = 50000,
   parameter int CW          = $clog2(REFRESH_DIV)
) (
   input  logic          clk,
   input  logic          rst,
   output logic [CW-1:0] cnt,
   output logic          tick
);

   assign tick = (cnt == CW'(REFRESH_DIV - 1));

   always_ff @(posedge clk) begin
      if (rst)       cnt <= '0;
      else if (tick) cnt <= '0;
      else           cnt <= cnt + 1'b1;
   end

endmodule

// File: rtl/display_scan_ctrl.sv
// Multi-digit 7-segment scan controller: shifting key-entry buffer, time-multiplexed
// onto one code-to-segment converter, with blanked guard cycles at each slot start.
module display_scan_ctrl
   import display_scan_ctrl_pkg::*;
#(
   parameter int N_DIGITS    = 4,
   parameter int REFRESH_DIV = 50000,
   parameter int GUARD_CYC   = 2
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                key_valid,
   input  logic [3:0]          key_code,
   input  logic                clear,
   output logic [3:0]          tecla,
   output logic [N_DIGITS-1:0] an,
   output logic                buf_full
);

   localparam int CW = $clog2(REFRESH_DIV);
   localparam int IW = $clog2(N_DIGITS + 1);
   localparam int SW = $clog2(N_DIGITS);
   localparam logic [IW-1:0]       LAST_IDX = IW'(N_DIGITS - 1);
   localparam logic [IW-1:0]       FULL_CNT = IW'(N_DIGITS);
   localparam logic [N_DIGITS-1:0] AN_ONE   = N_DIGITS'(1);

   key_t          ent [N_DIGITS];
   logic [IW-1:0] count;
   logic [IW-1:0] count_nx;
   logic [IW-1:0] idx;
   logic [CW-1:0] cnt;
   logic          tick;
   logic          accept;

   refresh_tick_gen #(
      .REFRESH_DIV (REFRESH_DIV),
      .CW          (CW)
   ) u_tick (
      .clk  (clk),
      .rst  (rst),
      .cnt  (cnt),
      .tick (tick)
   );

   // clear has priority; a key on a full buffer is silently dropped
   assign accept = key_valid && !clear && (count < FULL_CNT);

   always_comb begin
      count_nx = count;
      if (clear)       count_nx = '0;
      else if (accept) count_nx = count + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < N_DIGITS; i++) ent[i] <= KEY_NUL;
         count    <= '0;
         idx      <= '0;
         an       <= '1;
         tecla    <= KEY_NUL;
         buf_full <= 1'b0;
      end else begin
         count    <= count_nx;
         buf_full <= (count_nx == FULL_CNT);
         if (clear) begin
            for (int i = 0; i < N_DIGITS; i++) ent[i] <= KEY_NUL;
         end else if (accept) begin
            for (int i = N_DIGITS - 1; i > 0; i--) ent[i] <= ent[i-1];
            ent[0] <= key_code;
         end
         if (tick) idx <= (idx == LAST_IDX) ? '0 : idx + 1'b1;
         // output stage: one cycle behind (cnt, idx), anodes dark during the guard
         an    <= (cnt < CW'(GUARD_CYC)) ? '1 : ~(AN_ONE << idx);
         tecla <= ent[idx[SW-1:0]];
      end
   end

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Scoreboard bench for display_scan_ctrl (N_DIGITS=4, REFRESH_DIV=4, GUARD_CYC=1).
// Expected outputs are tagged with the post-reset cycle at which they must appear.
module tb_display_scan_ctrl;

   localparam int N   = 4;
   localparam int DIV = 4;
   localparam int G   = 1;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         key_valid = 1'b0;
   logic [3:0]   key_code = 4'h0;
   logic         clear = 1'b0;
   logic [3:0]   tecla;
   logic [N-1:0] an;
   logic         buf_full;

   typedef struct {
      int         when;
      logic [3:0] an;
      logic [3:0] tecla;
      logic       full;
      string      nm;
   } exp_t;

   exp_t q[$];
   int   t       = 0;
   int   checks  = 0;
   int   passed  = 0;

   always #5 clk = ~clk;

   display_scan_ctrl #(
      .N_DIGITS    (N),
      .REFRESH_DIV (DIV),
      .GUARD_CYC   (G)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .key_valid (key_valid),
      .key_code  (key_code),
      .clear     (clear),
      .tecla     (tecla),
      .an        (an),
      .buf_full  (buf_full)
   );

   // t = number of clock edges since reset was released (0 while in reset)
   always @(posedge clk) t <= rst ? 0 : t + 1;

   always @(negedge clk) begin : monitor
      exp_t e;
      while (q.size() > 0 && q[0].when < t) begin
         e = q.pop_front();
         checks++;
         $display("FAIL %s: check at cycle %0d skipped (now %0d)", e.nm, e.when, t);
      end
      if (q.size() > 0 && q[0].when == t) begin
         e = q.pop_front();
         checks++;
         if (an === e.an && tecla === e.tecla && buf_full === e.full)
            passed++;
         else
            $display("FAIL %s @%0d: got an=%b tecla=%h full=%b, want an=%b tecla=%h full=%b",
                     e.nm, t, an, tecla, buf_full, e.an, e.tecla, e.full);
      end
   end

   task automatic expect_at(input int w, input logic [3:0] a, input logic [3:0] tc,
                            input logic f, input string nm);
      exp_t e;
      e.when = w; e.an = a; e.tecla = tc; e.full = f; e.nm = nm;
      q.push_back(e);
   endtask

   task automatic goto(input int n);
      while (t < n) begin
         @(posedge clk); #1;
      end
   endtask

   task automatic press(input logic [3:0] c);
      key_valid = 1'b1;
      key_code  = c;
      @(posedge clk); #1;
      key_valid = 1'b0;
   endtask

   task automatic reset_hold(input int n);
      rst = 1'b1; key_valid = 1'b0; clear = 1'b0;
      @(posedge clk); #1;
      expect_at(0, 4'b1111, 4'hF, 1'b0, "in_reset");
      repeat (n - 1) begin
         @(posedge clk); #1;
      end
      rst = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      while (q.size() > 0 && n < 100) begin
         @(posedge clk); #1;
         n++;
      end
      if (q.size() > 0) begin
         checks++;
         $display("FAIL drain: %0d checks pending, want 0", q.size());
         q.delete();
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached, want completion");
      $fatal(1, "watchdog");
   end

   initial begin
      // Test 1: reset values and the bare scan sequence
      reset_hold(3);
      expect_at(1, 4'b1111, 4'hF, 1'b0, "t1_guard0");
      expect_at(2, 4'b1110, 4'hF, 1'b0, "t1_d0a");
      expect_at(3, 4'b1110, 4'hF, 1'b0, "t1_d0b");
      expect_at(4, 4'b1110, 4'hF, 1'b0, "t1_d0c");
      expect_at(5, 4'b1111, 4'hF, 1'b0, "t1_guard1");
      expect_at(6, 4'b1101, 4'hF, 1'b0, "t1_d1a");
      expect_at(7, 4'b1101, 4'hF, 1'b0, "t1_d1b");
      expect_at(8, 4'b1101, 4'hF, 1'b0, "t1_d1c");
      drain();

      // Test 2: keys 1,2,3 -> buffer {F,1,2,3}
      reset_hold(2);
      expect_at(3,  4'b1110, 4'h1, 1'b0, "t2_after1");
      expect_at(4,  4'b1110, 4'h2, 1'b0, "t2_after2");
      expect_at(5,  4'b1111, 4'h2, 1'b0, "t2_guard");
      expect_at(17, 4'b1111, 4'h3, 1'b0, "t2_guard_d0");
      expect_at(18, 4'b1110, 4'h3, 1'b0, "t2_d0a");
      expect_at(19, 4'b1110, 4'h3, 1'b0, "t2_d0b");
      expect_at(20, 4'b1110, 4'h3, 1'b0, "t2_d0c");
      expect_at(21, 4'b1111, 4'h2, 1'b0, "t2_guard_d1");
      expect_at(22, 4'b1101, 4'h2, 1'b0, "t2_d1");
      expect_at(26, 4'b1011, 4'h1, 1'b0, "t2_d2");
      expect_at(30, 4'b0111, 4'hF, 1'b0, "t2_d3");
      goto(1);
      press(4'h1); press(4'h2); press(4'h3);
      drain();

      // Tests 3 and 4: overflow drop, then clear colliding with a key
      reset_hold(2);
      expect_at(4,  4'b1110, 4'h2, 1'b0, "t3_not_full");
      expect_at(5,  4'b1111, 4'h2, 1'b1, "t3_full");
      expect_at(7,  4'b1101, 4'h3, 1'b1, "t3_drop_d1");
      expect_at(18, 4'b1110, 4'h4, 1'b1, "t3_d0");
      expect_at(22, 4'b1101, 4'h3, 1'b1, "t3_d1");
      expect_at(26, 4'b1011, 4'h2, 1'b1, "t3_d2");
      expect_at(30, 4'b0111, 4'h1, 1'b1, "t3_d3");
      expect_at(34, 4'b1110, 4'h4, 1'b0, "t4_clear_full");
      expect_at(35, 4'b1110, 4'hF, 1'b0, "t4_cleared");
      expect_at(36, 4'b1110, 4'hF, 1'b0, "t4_no7");
      expect_at(50, 4'b1110, 4'h7, 1'b0, "t4_d0_7");
      expect_at(54, 4'b1101, 4'hF, 1'b0, "t4_d1_blank");
      goto(1);
      press(4'h1); press(4'h2); press(4'h3); press(4'h4); press(4'h5);
      goto(33);
      clear = 1'b1; key_valid = 1'b1; key_code = 4'h7;
      @(posedge clk); #1;
      clear = 1'b0; key_valid = 1'b0;
      goto(36);
      press(4'h7);
      drain();

      // Test 5: reset mid-slot with a full buffer
      reset_hold(2);
      expect_at(10, 4'b1011, 4'h2, 1'b1, "t5_before");
      goto(1);
      press(4'h1); press(4'h2); press(4'h3); press(4'h4);
      goto(10);
      rst = 1'b1;
      @(posedge clk); #1;
      expect_at(0, 4'b1111, 4'hF, 1'b0, "t5_reset");
      rst = 1'b0;
      expect_at(1, 4'b1111, 4'hF, 1'b0, "t5_guard");
      expect_at(2, 4'b1110, 4'hF, 1'b0, "t5_d0a");
      expect_at(3, 4'b1110, 4'hF, 1'b0, "t5_d0b");
      drain();

      // Test 6: key on the idx 3 -> 0 wrap cycle
      reset_hold(2);
      expect_at(13, 4'b1111, 4'hF, 1'b0, "t6_guard_d3");
      expect_at(14, 4'b0111, 4'hF, 1'b0, "t6_d3a");
      expect_at(16, 4'b0111, 4'hF, 1'b0, "t6_d3c");
      expect_at(17, 4'b1111, 4'h9, 1'b0, "t6_guard_d0");
      expect_at(18, 4'b1110, 4'h9, 1'b0, "t6_d0a");
      expect_at(20, 4'b1110, 4'h9, 1'b0, "t6_d0c");
      expect_at(22, 4'b1101, 4'hF, 1'b0, "t6_d1");
      goto(15);
      press(4'h9);
      drain();

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
